// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the sequential EX-stage ALU.
// MUL/DIVU/REMU are the iterative ops; everything else completes in one cycle.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mdu_op(
    input logic [3:0] op
  );
    return (op == OP_MUL) ||
           (op == OP_DIVU) ||
           (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// done is raised during the last iteration; result then shows the final value.
module seq_muldiv_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  logic          run;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [N-1:0]  acc;
  logic [N-1:0]  sh;
  logic [N-1:0]  opd;
  logic [N-1:0]  acc_nx;
  logic [N-1:0]  sh_nx;
  logic [N-1:0]  opd_nx;
  logic [N:0]    part;
  logic [N:0]    trial;
  logic          fits;

  // MUL: acc=product, sh=multiplier, opd=multiplicand.
  // DIV: acc=remainder, sh=dividend/quotient, opd=divisor.
  always_comb begin
    part   = {acc, sh[N-1]};
    trial  = part - {1'b0, opd};
    fits   = (part >= {1'b0, opd});
    acc_nx = acc;
    sh_nx  = sh;
    opd_nx = opd;
    if (op_q == OP_MUL) begin
      acc_nx = sh[0] ? acc + opd : acc;
      sh_nx  = sh >> 1;
      opd_nx = opd << 1;
    end else begin
      acc_nx = fits ? trial[N-1:0] : part[N-1:0];
      sh_nx  = {sh[N-2:0], fits};
    end
  end

  assign done   = run && (cnt == CW'(N-1));
  assign result = (op_q == OP_DIVU) ? sh_nx : acc_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      acc  <= '0;
      sh   <= '0;
      opd  <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      acc  <= '0;
      sh   <= (op == OP_MUL) ? b : a;
      opd  <= (op == OP_MUL) ? a : b;
    end else if (run) begin
      acc <= acc_nx;
      sh  <= sh_nx;
      opd <= opd_nx;
      cnt <= cnt + 1'b1;
      if (done) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus an
// optional iterative MUL/DIVU/REMU path, with registered result and flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter bit EN_MDU = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUout,
  output logic         ZeroFlag,
  output logic         NegFlag,
  output logic         CarryFlag,
  output logic         OvfFlag
);

  localparam int SW = $clog2(N);

  state_t        state;
  logic          accept;
  logic          mdu_go;
  logic          md_start;
  logic          md_done;
  logic [N-1:0]  md_result;
  logic [SW-1:0] shamt;
  logic [N:0]    sum;
  logic [N:0]    dif;
  logic [N-1:0]  res;
  logic          c;
  logic          v;

  assign accept   = in_valid && in_ready;
  assign mdu_go   = EN_MDU && is_mdu_op(sel);
  assign md_start = accept && mdu_go;
  assign shamt    = B[SW-1:0];

  // SUB as A + ~B + 1 so the carry out reads as "no borrow".
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (sel)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_ADD: begin
        res = sum[N-1:0];
        c   = sum[N];
        v   = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_SUB: begin
        res = dif[N-1:0];
        c   = dif[N];
        v   = (A[N-1] != B[N-1]) && (dif[N-1] != A[N-1]);
      end
      OP_SLT:  res = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: res = {{(N-1){1'b0}}, A < B};
      OP_SLL:  res = A << shamt;
      OP_SRL:  res = A >> shamt;
      OP_SRA:  res = $unsigned($signed(A) >>> shamt);
      default: res = '0;
    endcase
  end

  generate
    if (EN_MDU) begin : g_mdu
      seq_muldiv_unit #(
        .N(N)
      ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (sel),
        .a     (A),
        .b     (B),
        .done  (md_done),
        .result(md_result)
      );
    end else begin : g_no_mdu
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUout    <= '0;
      ZeroFlag  <= 1'b0;
      NegFlag   <= 1'b0;
      CarryFlag <= 1'b0;
      OvfFlag   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (mdu_go) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              ALUout    <= res;
              ZeroFlag  <= (res == '0);
              NegFlag   <= res[N-1];
              CarryFlag <= c;
              OvfFlag   <= v;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            ALUout    <= md_result;
            ZeroFlag  <= (md_result == '0);
            NegFlag   <= md_result[N-1];
            CarryFlag <= 1'b0;
            OvfFlag   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at N=32 and N=8 against an arithmetic model.
// Drivers push expectations on accept; negedge monitors pop and compare.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv, ir, ov, ordy, zf, nf, cf, vf;
  logic [3:0]  sel;
  logic [31:0] a, b, y;
  logic        iv8, ir8, ov8, ordy8, zf8, nf8, cf8, vf8;
  logic [3:0]  sel8;
  logic [7:0]  a8, b8, y8;

  seq_alu #(.N(32), .EN_MDU(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .sel(sel),
    .A(a), .B(b), .out_valid(ov), .out_ready(ordy), .ALUout(y),
    .ZeroFlag(zf), .NegFlag(nf), .CarryFlag(cf), .OvfFlag(vf)
  );

  seq_alu #(.N(8), .EN_MDU(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .sel(sel8),
    .A(a8), .B(b8), .out_valid(ov8), .out_ready(ordy8), .ALUout(y8),
    .ZeroFlag(zf8), .NegFlag(nf8), .CarryFlag(cf8), .OvfFlag(vf8)
  );

  typedef struct {
    longint unsigned res;
    bit z, n, c, v;
    int lat;
    int acc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t cur32, cur8;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit pv32 = 0, pv8 = 0, bp_rand = 0;
  logic [35:0] snap32;
  logic [11:0] snap8;
  vec_t dir [13];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on n-bit values.
  function automatic exp_t model(input int n, input logic [3:0] op,
                                 input longint unsigned ua0,
                                 input longint unsigned ub0);
    exp_t e;
    longint unsigned m, ua, ub, t, half;
    longint sa, sb, st, hi, lo;
    int sh;
    m    = (64'd1 << n) - 1;
    half = (m + 1) / 2;
    ua   = ua0 & m;
    ub   = ub0 & m;
    sa   = (ua >= half) ? longint'(ua) - longint'(m + 1) : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - longint'(m + 1) : longint'(ub);
    hi   = longint'(half) - 1;
    lo   = -longint'(half);
    sh   = int'(ub % longint'(n));
    e.c = 0; e.v = 0; e.lat = 1; e.acc = 0; t = 0;
    case (op)
      OP_AND:  t = ua & ub;
      OP_OR:   t = ua | ub;
      OP_XOR:  t = ua ^ ub;
      OP_ADD: begin
        t = ua + ub; e.c = (t > m);
        st = sa + sb; e.v = (st > hi) || (st < lo);
      end
      OP_SUB: begin
        t = ua - ub; e.c = (ua >= ub);
        st = sa - sb; e.v = (st > hi) || (st < lo);
      end
      OP_SLT:  t = (sa < sb) ? 1 : 0;
      OP_SLTU: t = (ua < ub) ? 1 : 0;
      OP_SLL:  t = ua << sh;
      OP_SRL:  t = ua >> sh;
      OP_SRA:  t = longint'(sa >>> sh);
      OP_MUL:  begin t = ua * ub; e.lat = n + 1; end
      OP_DIVU: begin t = (ub == 0) ? m : ua / ub; e.lat = n + 1; end
      OP_REMU: begin t = (ub == 0) ? ua : ua % ub; e.lat = n + 1; end
      default: t = 0;
    endcase
    e.res = t & m;
    e.z = (e.res == 0);
    e.n = ((e.res >> (n - 1)) & 1) != 0;
    return e;
  endfunction

  task automatic issue32(input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] yy);
    exp_t e;
    int w = 0;
    @(posedge clk); #2;
    sel = op; a = x; b = yy; iv = 1'b1;
    while (!ir && w < 300) begin @(posedge clk); #2; w++; end
    if (!ir) begin
      compared++; mismatched++;
      $display("FAIL accept32_timeout: got in_ready 0 required 1");
      iv = 1'b0;
      return;
    end
    e = model(32, op, x, yy);
    e.acc = cyc + 1;
    q32.push_back(e);
    @(posedge clk); #2;
    iv = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] x,
                        input logic [7:0] yy);
    exp_t e;
    int w = 0;
    @(posedge clk); #2;
    sel8 = op; a8 = x; b8 = yy; iv8 = 1'b1;
    while (!ir8 && w < 300) begin @(posedge clk); #2; w++; end
    if (!ir8) begin
      compared++; mismatched++;
      $display("FAIL accept8_timeout: got in_ready 0 required 1");
      iv8 = 1'b0;
      return;
    end
    e = model(8, op, x, yy);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #2;
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 400) begin
      @(negedge clk); w++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d pending required 0",
               q32.size() + q8.size());
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      pv32 = 0;
    end else if (ov) begin
      chk("in_ready_in_done", ir, 1'b0);
      if (!pv32) begin
        if (q32.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected32: got %0h required none", y);
        end else begin
          cur32 = q32.pop_front();
          chk("result32", y, cur32.res);
          chk("flags32", {zf, nf, cf, vf},
              {cur32.z, cur32.n, cur32.c, cur32.v});
          chk("latency32", cyc - cur32.acc + 1, cur32.lat);
        end
        snap32 = {y, zf, nf, cf, vf};
      end else begin
        chk("hold32", {y, zf, nf, cf, vf}, snap32);
      end
      pv32 = !ordy;
    end else begin
      pv32 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      pv8 = 0;
    end else if (ov8) begin
      if (!pv8) begin
        if (q8.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected8: got %0h required none", y8);
        end else begin
          cur8 = q8.pop_front();
          chk("result8", y8, cur8.res);
          chk("flags8", {zf8, nf8, cf8, vf8},
              {cur8.z, cur8.n, cur8.c, cur8.v});
          chk("latency8", cyc - cur8.acc + 1, cur8.lat);
        end
        snap8 = {y8, zf8, nf8, cf8, vf8};
      end else begin
        chk("hold8", {y8, zf8, nf8, cf8, vf8}, snap8);
      end
      pv8 = !ordy8;
    end else begin
      pv8 = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (bp_rand) ordy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0; ordy = 1'b1; ordy8 = 1'b1;
    iv = 1'b0; sel = '0; a = '0; b = '0;
    iv8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
    dir = '{
      '{OP_ADD,  32'h7FFF_FFFF, 32'h1},
      '{OP_SUB,  32'd5,         32'd5},
      '{OP_SUB,  32'd3,         32'd5},
      '{OP_SLT,  32'hFFFF_FFFF, 32'h1},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'h1},
      '{OP_SRA,  32'h8000_0000, 32'd4},
      '{OP_MUL,  32'h0001_0003, 32'h0002_0005},
      '{OP_DIVU, 32'd100,       32'd7},
      '{OP_REMU, 32'd100,       32'd7},
      '{OP_DIVU, 32'hDEAD_BEEF, 32'h0},
      '{OP_REMU, 32'hDEAD_BEEF, 32'h0},
      '{OP_SLL,  32'h0000_0001, 32'h0000_0025},
      '{4'b0100, 32'h1234_5678, 32'h9ABC_DEF0}
    };

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out32", {ov, y, zf, nf, cf, vf}, '0);
    chk("reset_out8", {ov8, y8, zf8, nf8, cf8, vf8}, '0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready32", ir, 1'b1);
    chk("reset_in_ready8", ir8, 1'b1);

    // Abort a multiply part-way through.
    issue32(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_out", {ov, y, zf, nf, cf, vf}, '0);
    q32.delete();
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", ir, 1'b1);
    repeat (40) @(negedge clk);

    foreach (dir[i]) issue32(dir[i].op, dir[i].x, dir[i].y);
    drain();

    // Backpressure: hold result, new request must wait.
    @(posedge clk); #2 ordy = 1'b0;
    issue32(OP_ADD, 32'h0000_00F0, 32'h0000_000F);
    for (int w = 0; w < 5 && !ov; w++) @(negedge clk);
    @(posedge clk); #2;
    sel = OP_XOR; a = 32'hA5A5_0F0F; b = 32'hFFFF_0000; iv = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", ir, 1'b0);
      chk("bp_out_valid", ov, 1'b1);
    end
    @(posedge clk); #2 ordy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", ir, 1'b1);
    e = model(32, OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000);
    e.acc = cyc + 1;
    q32.push_back(e);
    @(posedge clk); #2 iv = 1'b0;
    drain();

    bp_rand = 1'b1;
    repeat (60) issue32(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
    drain();
    bp_rand = 1'b0;
    @(posedge clk); #2 ordy = 1'b1;

    issue8(OP_ADD, 8'hFF, 8'h01);
    issue8(OP_SUB, 8'h80, 8'h01);
    issue8(OP_MUL, 8'h0F, 8'h11);
    issue8(OP_DIVU, 8'hC8, 8'h00);
    repeat (20) issue8(4'($urandom_range(0, 15)), 8'($urandom()),
                       8'($urandom()));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
